psum_acc_layer: RTL and testbench
=================================

// Module: psum_acc_layer
// PURPOSE
//  Downstream of the SIZE x SIZE multiply array: accumulates its 32-bit per-cell products
//  over a K-long reduction, one beat per cycle. On the last beat it drains the SIZE x SIZE
//  result matrix one row per cycle over a valid/ready stream toward the output buffer.
// PARAMETERS
//  SIZE     8   array edge; SIZE*SIZE cells, power of two, >=2
//  PSUM_WID 32  width of each incoming product
//  ACC_WID  32  accumulator width (>= PSUM_WID); arithmetic is modulo 2^ACC_WID
// PORTS
//  clock     in  1                    single clock; all logic on posedge
//  rst       in  1                    synchronous, active-high reset
//  psums_in  in  PSUM_WID*SIZE*SIZE   cell (i,j) at [(i*SIZE+j)*PSUM_WID +: PSUM_WID]
//  in_valid  in  1                    psums_in beat valid
//  in_first  in  1                    beat starts a new reduction (overwrite, no add)
//  in_last   in  1                    beat ends the reduction
//  in_ready  out 1                    block accepts a beat this cycle
//  row_out   out ACC_WID*SIZE         row r, element j at [j*ACC_WID +: ACC_WID]
//  row_idx   out $clog2(SIZE)         row index r of row_out
//  out_valid out 1                    row_out/row_idx valid
//  out_ready in  1                    downstream accepts the row
//  busy      out 1                    high in ACC or DRAIN
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset: state=IDLE, every acc cell = 0, row_idx = 0, out_valid = 0, busy = 0, in_ready = 1.
//    Reset overrides everything, including mid-ACC or mid-DRAIN: the partial result is discarded.
//  Beat accepted = in_valid & in_ready. in_ready = (state != DRAIN), decoded from state only.
//  FSM:
//    IDLE:  accepted beat -> acc = sext(psum). Go to DRAIN if in_last, else to ACC.
//           in_first is don't-care in IDLE: the beat is always treated as first.
//    ACC:   accepted beat -> acc = in_first ? sext(psum) : acc + sext(psum).
//           Go to DRAIN if in_last. in_first in ACC restarts the reduction silently.
//           in_valid low -> hold state and acc.
//    DRAIN: out_valid = 1, in_ready = 0. On out_valid & out_ready, row_idx increments.
//           Handshake at row_idx == SIZE-1 -> row_idx = 0, go to IDLE.
//  Latency: the first row is valid the cycle after the last beat is accepted.
//    One row per cycle while out_ready = 1, so a drain takes SIZE cycles minimum.
//  Drain output: row_out is a registered copy of acc row row_idx.
//    It stays stable while out_valid & !out_ready. acc is not modified during DRAIN.
//  Single-beat reduction (in_first & in_last together) is legal: result = that beat.
//  Arithmetic: psum is sign-extended to ACC_WID, addition wraps modulo 2^ACC_WID,
//    no saturation and no overflow flag.
//  Back-to-back: after the final drain handshake, in_ready = 1 on the next cycle.
//    No overlap of drain and accumulation.
//  X safety: psums_in is ignored while !in_valid. out_ready is ignored outside DRAIN.
// STRUCTURE
//  Shared package sdavinci_pkg: PSUM_WID default, state encoding
//    (IDLE=2'd0, ACC=2'd1, DRAIN=2'd2), row-index width function.
//  Sub-module psum_acc_cell: one ACC_WID register.
//    Inputs: en, first, psum. Performs sext-and-overwrite or add.
//    Generated SIZE*SIZE times in the same (i,j) index order as psums_in.
//  Top level: FSM, row_idx counter, row mux into the row_out register.
// TESTING
//  1 SIZE=2, one beat: all cells = 5, first & last -> rows 0 and 1 both = {5,5};
//    out_valid on the next cycle, back in IDLE after 2 handshakes.
//  2 K=4 beats, cell(i,j) = i*SIZE+j+1 each beat -> row i element j = 4*(i*SIZE+j+1).
//  3 Wrap and sign: cell = 32'h7FFFFFFF twice -> 32'hFFFFFFFE.
//    Cell = 32'hFFFFFFFF (-1) then 3 -> 2.
//  4 Backpressure: out_ready low 3 cycles during row 1 -> row_out/row_idx held;
//    in_valid asserted in DRAIN is not accepted (in_ready = 0) and acc is unchanged.
//  5 rst pulsed during row 2 of a drain -> next cycle out_valid = 0, state IDLE,
//    acc = 0, in_ready = 1; a new single beat of 7 drains rows of 7.
//  6 in_first mid-ACC: beats 10 and 20, then first = 3, then last = 4 -> result 7.

Source files
------------

// File: rtl/sdavinci_pkg.sv
// Shared definitions for the systolic-array datapath blocks.
// Holds the product-width default, the drain FSM state encoding and index-width helpers.
package sdavinci_pkg;

  localparam int PSUM_WID_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Row-index width; a one-row array still needs a 1-bit index.
  function automatic int idx_wid(input int size);
    if (size < 32'sd2) begin
      return 32'sd1;
    end else begin
      return $clog2(size);
    end
  endfunction

endpackage

// File: rtl/psum_acc_cell.sv
// One accumulator cell: sign-extends an incoming product and either overwrites or adds.
// The next value is exported so the drain path can capture a row in the same cycle it is written.
module psum_acc_cell #(
  parameter int PSUM_WID = 32,
  parameter int ACC_WID  = 32
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                en,
  input  logic                first,
  input  logic [PSUM_WID-1:0] psum,
  output logic [ACC_WID-1:0]  acc_next
);

  logic [ACC_WID-1:0] acc;
  logic [ACC_WID-1:0] ext;

  assign ext = ACC_WID'($signed(psum));

  // Overwrite on the first beat, otherwise wrap-around add.
  always_comb begin
    acc_next = acc;
    if (en) begin
      if (first) begin
        acc_next = ext;
      end else begin
        acc_next = acc + ext;
      end
    end else begin
      acc_next = acc;
    end
  end

  // Accumulator register.
  always_ff @(posedge clock) begin
    if (rst) begin
      acc <= '0;
    end else begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/psum_acc_layer.sv
// Partial-sum accumulation layer: sums SIZE x SIZE products over a K-beat reduction,
// then drains the result one row per cycle over a valid/ready stream.
module psum_acc_layer
  import sdavinci_pkg::*;
#(
  parameter int SIZE     = 8,
  parameter int PSUM_WID = PSUM_WID_DEF,
  parameter int ACC_WID  = 32
) (
  input  logic                          clock,
  input  logic                          rst,
  input  logic [PSUM_WID*SIZE*SIZE-1:0] psums_in,
  input  logic                          in_valid,
  input  logic                          in_first,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic [ACC_WID*SIZE-1:0]       row_out,
  output logic [idx_wid(SIZE)-1:0]      row_idx,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy
);

  localparam int IW = idx_wid(SIZE);
  localparam int NC = SIZE * SIZE;

  state_t                  state;
  state_t                  state_next;
  logic                    accept;
  logic                    cell_first;
  logic                    last_row;
  logic [IW-1:0]           idx_next;
  logic [ACC_WID*SIZE-1:0] row_sel;
  logic [ACC_WID-1:0]      acc_next [NC];

  assign in_ready   = (state != ST_DRAIN);
  assign out_valid  = (state == ST_DRAIN);
  assign busy       = (state != ST_IDLE);
  assign accept     = in_valid & in_ready;
  assign cell_first = (state == ST_IDLE) | in_first;
  assign last_row   = (row_idx == IW'(SIZE - 1));

  for (genvar c = 0; c < NC; c++) begin : g_cell
    psum_acc_cell #(
      .PSUM_WID(PSUM_WID),
      .ACC_WID (ACC_WID)
    ) u_cell (
      .clock   (clock),
      .rst     (rst),
      .en      (accept),
      .first   (cell_first),
      .psum    (psums_in[c*PSUM_WID +: PSUM_WID]),
      .acc_next(acc_next[c])
    );
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_ACC: begin
        if (accept) begin
          state_next = in_last ? ST_DRAIN : ST_ACC;
        end else begin
          state_next = state;
        end
      end
      ST_DRAIN: begin
        if (out_ready && last_row) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_DRAIN;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Row pointer advances on each drain handshake and wraps after the last row.
  always_comb begin
    idx_next = row_idx;
    if ((state == ST_DRAIN) && out_ready) begin
      if (last_row) begin
        idx_next = '0;
      end else begin
        idx_next = row_idx + IW'(1);
      end
    end else begin
      idx_next = row_idx;
    end
  end

  // Cell index is {row, col} since SIZE is a power of two.
  always_comb begin
    row_sel = '0;
    for (int j = 0; j < SIZE; j++) begin
      row_sel[j*ACC_WID +: ACC_WID] = acc_next[{idx_next, IW'(j)}];
    end
  end

  // State, row pointer and the registered row copy.
  always_ff @(posedge clock) begin
    if (rst) begin
      state   <= ST_IDLE;
      row_idx <= '0;
      row_out <= '0;
    end else begin
      state   <= state_next;
      row_idx <= idx_next;
      row_out <= row_sel;
    end
  end

endmodule

// File: tb/tb_psum_acc_layer.sv
// Directed and randomized bench for psum_acc_layer with a signed-sum reference model.
module tb_psum_acc_layer;

  localparam int SIZE = 4;
  localparam int PW   = 32;
  localparam int AW   = 32;
  localparam int IW   = $clog2(SIZE);
  localparam int NC   = SIZE * SIZE;

  logic              clock = 1'b0;
  logic              rst = 1'b1;
  logic [PW*NC-1:0]  psums_in = '0;
  logic              in_valid = 1'b0;
  logic              in_first = 1'b0;
  logic              in_last = 1'b0;
  logic              out_ready = 1'b0;
  logic              in_ready;
  logic [AW*SIZE-1:0] row_out;
  logic [IW-1:0]     row_idx;
  logic              out_valid;
  logic              busy;

  int     passed = 0;
  int     fails = 0;
  int     total = 0;
  longint msum [NC];
  bit     mfresh = 1'b1;

  always #5 clock = ~clock;

  psum_acc_layer #(.SIZE(SIZE), .PSUM_WID(PW), .ACC_WID(AW)) dut (
    .clock(clock), .rst(rst), .psums_in(psums_in), .in_valid(in_valid),
    .in_first(in_first), .in_last(in_last), .in_ready(in_ready), .row_out(row_out),
    .row_idx(row_idx), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  task automatic chk_b(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_row(input string tag, input logic [AW*SIZE-1:0] obs, input logic [AW*SIZE-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW*NC-1:0] fill_const(input logic [PW-1:0] v);
    logic [PW*NC-1:0] p;
    for (int c = 0; c < NC; c++) p[c*PW +: PW] = v;
    return p;
  endfunction

  function automatic logic [PW*NC-1:0] rand_vec();
    logic [PW*NC-1:0] p;
    for (int c = 0; c < NC; c++) p[c*PW +: PW] = $urandom;
    return p;
  endfunction

  function automatic logic [AW*SIZE-1:0] exp_row(input int r);
    logic [AW*SIZE-1:0] e;
    for (int j = 0; j < SIZE; j++) e[j*AW +: AW] = msum[r*SIZE + j][AW-1:0];
    return e;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) msum[c] = 0;
    mfresh = 1'b1;
  endtask

  // Offer idle cycles carrying junk, then one real beat; the model sums signed values.
  task automatic do_beat(input logic [PW*NC-1:0] p, input bit f, input bit l, input int gap);
    for (int g = 0; g < gap; g++) begin
      @(negedge clock);
      in_valid = 1'b0;
      psums_in = rand_vec();
      in_first = 1'($urandom);
      in_last  = 1'($urandom);
      chk_b("gap_in_ready", 32'(in_ready), 32'd1);
    end
    @(negedge clock);
    psums_in = p;
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    chk_b("beat_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    psums_in = rand_vec();
    for (int c = 0; c < NC; c++) begin
      if (f || mfresh) msum[c] = longint'($signed(p[c*PW +: PW]));
      else msum[c] = msum[c] + longint'($signed(p[c*PW +: PW]));
    end
    mfresh = l;
  endtask

  // Drain all rows, optionally stalling one row or resetting at one row.
  task automatic drain(input int stall_row, input int stall_cycles, input int rst_row);
    for (int r = 0; r < SIZE; r++) begin
      chk_b("drain_valid", 32'(out_valid), 32'd1);
      chk_b("drain_busy", 32'(busy), 32'd1);
      chk_b("drain_idx", 32'(row_idx), 32'(r));
      chk_row("drain_row", row_out, exp_row(r));
      if (r == rst_row) begin
        rst = 1'b1;
        @(posedge clock);
        #1;
        rst = 1'b0;
        model_reset();
        chk_b("rst_out_valid", 32'(out_valid), 32'd0);
        chk_b("rst_in_ready", 32'(in_ready), 32'd1);
        chk_b("rst_busy", 32'(busy), 32'd0);
        chk_b("rst_idx", 32'(row_idx), 32'd0);
        @(posedge clock);
        #1;
        chk_row("rst_acc_row0", row_out, exp_row(0));
        return;
      end
      if (r == stall_row) begin
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_first  = 1'b1;
        in_last   = 1'b1;
        psums_in  = rand_vec();
        for (int k = 0; k < stall_cycles; k++) begin
          @(posedge clock);
          #1;
          chk_b("stall_in_ready", 32'(in_ready), 32'd0);
          chk_b("stall_valid", 32'(out_valid), 32'd1);
          chk_b("stall_idx", 32'(row_idx), 32'(r));
          chk_row("stall_row", row_out, exp_row(r));
        end
        in_valid = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clock);
      #1;
    end
    chk_b("post_valid", 32'(out_valid), 32'd0);
    chk_b("post_in_ready", 32'(in_ready), 32'd1);
    chk_b("post_busy", 32'(busy), 32'd0);
    chk_b("post_idx", 32'(row_idx), 32'd0);
    out_ready = 1'($urandom);
  endtask

  initial begin
    logic [PW*NC-1:0] p;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk_b("reset_valid", 32'(out_valid), 32'd0);
    chk_b("reset_in_ready", 32'(in_ready), 32'd1);
    chk_b("reset_busy", 32'(busy), 32'd0);
    chk_b("reset_idx", 32'(row_idx), 32'd0);
    chk_row("reset_row", row_out, '0);
    rst = 1'b0;

    // single beat of 5s
    do_beat(fill_const(32'd5), 1'b1, 1'b1, 0);
    chk_row("t1_row0_const", row_out, {SIZE{32'd5}});
    drain(-1, 0, -1);

    // K=4, cell c gets c+1 every beat
    for (int c = 0; c < NC; c++) p[c*PW +: PW] = 32'(c + 1);
    for (int b = 0; b < 4; b++) do_beat(p, b == 0, b == 3, 0);
    chk_b("t2_cell1", row_out[AW +: AW], 32'd8);
    drain(-1, 0, -1);

    // wrap (even cells) and sign (odd cells)
    for (int c = 0; c < NC; c++) p[c*PW +: PW] = (c % 2 == 0) ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
    do_beat(p, 1'b1, 1'b0, 0);
    for (int c = 0; c < NC; c++) p[c*PW +: PW] = (c % 2 == 0) ? 32'h7FFF_FFFF : 32'd3;
    do_beat(p, 1'b0, 1'b1, 1);
    chk_b("t3_wrap", row_out[0 +: AW], 32'hFFFF_FFFE);
    chk_b("t3_sign", row_out[AW +: AW], 32'd2);
    drain(-1, 0, -1);

    // backpressure on row 1 with a beat offered during the drain
    for (int b = 0; b < 3; b++) do_beat(rand_vec(), b == 0, b == 2, 0);
    drain(1, 3, -1);

    // reset during row 2, then a fresh single beat of 7
    for (int b = 0; b < 2; b++) do_beat(rand_vec(), b == 0, b == 1, 0);
    drain(-1, 0, 2);
    do_beat(fill_const(32'd7), 1'b0, 1'b1, 0);
    chk_row("t5_row0_const", row_out, {SIZE{32'd7}});
    drain(-1, 0, -1);

    // restart mid-reduction
    do_beat(fill_const(32'd10), 1'b1, 1'b0, 0);
    do_beat(fill_const(32'd20), 1'b0, 1'b0, 0);
    do_beat(fill_const(32'd3), 1'b1, 1'b0, 0);
    do_beat(fill_const(32'd4), 1'b0, 1'b1, 0);
    chk_row("t6_row0_const", row_out, {SIZE{32'd7}});
    drain(-1, 0, -1);

    // randomized reductions with gaps and stalls
    for (int t = 0; t < 8; t++) begin
      int k;
      k = $urandom_range(1, 5);
      for (int b = 0; b < k; b++)
        do_beat(rand_vec(), (b == 0) || ($urandom_range(0, 7) == 0), b == k - 1, $urandom_range(0, 2));
      drain($urandom_range(0, SIZE - 1), $urandom_range(0, 2), -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
